// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream (16-bit word count, then words) into imem writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CSUM_EN is defined.
module imem_loader #(
   parameter int          DEPTH     = 32,
   parameter logic [31:0] BASE_ADDR = 32'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_wr_en,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_data,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEN0  = 3'd1;
   localparam logic [2:0] S_LEN1  = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_CSUM  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [2:0] S_ERROR = 3'd7;

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   logic [2:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   logic        byte_fire;
   logic [15:0] len_full;
   logic [15:0] cnt_inc;

   assign byte_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
   assign byte_fire  = byte_valid & byte_ready;
   assign len_full   = {byte_data, len_q[7:0]};
   assign cnt_inc    = cnt_q + 16'd1;

   assign imem_wr_en = (state_q == S_WRITE);
   assign imem_addr  = addr_q;
   assign imem_data  = data_q;
   assign cpu_hold   = (state_q != S_DONE);
   assign busy       = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA) ||
                       (state_q == S_WRITE) || (state_q == S_CSUM);
   assign done       = (state_q == S_DONE);
   assign error      = (state_q == S_ERROR);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
`ifdef IMEM_LOADER_CSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN0;
               cnt_d   = 16'd0;
               addr_d  = BASE_ADDR;
               idx_d   = 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
               csum_d  = 8'd0;
`endif
            end
         end
         S_LEN0: begin
            if (byte_fire) begin
               len_d[7:0] = byte_data;
               state_d    = S_LEN1;
            end
         end
         S_LEN1: begin
            if (byte_fire) begin
               len_d = len_full;
               idx_d = 2'd0;
               if (len_full == 16'd0) begin
                  state_d = S_DONE;
               end else if ({1'b0, len_full} > DEPTH_W) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (byte_fire) begin
               data_d[{idx_q, 3'b000} +: 8] = byte_data;
               idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
               csum_d = csum_q ^ byte_data;
`endif
               if (idx_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            // Strobe is this cycle; address/count advance as it retires.
            addr_d = addr_q + 32'd1;
            cnt_d  = cnt_inc;
            if (cnt_inc == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_DATA;
            end
         end
         S_CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
            if (byte_fire) begin
               state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
            end
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= BASE_ADDR;
         data_q  <= 32'd0;
         len_q   <= 16'd0;
         cnt_q   <= 16'd0;
         idx_q   <= 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q  <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected writes go to a scoreboard queue checked by a monitor.
module tb_imem_loader;

   localparam int          DEPTH = 32;
   localparam logic [31:0] BASE  = 32'd0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'd0;
   logic        byte_ready;
   logic        imem_wr_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;

   imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_wr_en (imem_wr_en),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          writes_seen = 0;
   logic [63:0] sb[$];
   logic [31:0] words[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the scoreboard and last one cycle.
   initial begin
      logic        prev_wr;
      logic [63:0] exp;
      prev_wr = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && imem_wr_en) begin
            chk("wr_pulse_width", {31'd0, prev_wr}, 32'd0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %h data %h expected none", imem_addr, imem_data);
            end else begin
               exp = sb.pop_front();
               chk("wr_addr", imem_addr, exp[63:32]);
               chk("wr_data", imem_data, exp[31:0]);
            end
            writes_seen++;
         end
         prev_wr = rst_n & imem_wr_en;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) begin
         while ($urandom_range(1, 0) == 1) @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL byte_timeout: got byte_ready=0 for 50 cycles expected 1");
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_load(input logic [15:0] len, input int nwords, input bit gaps, input bit good_csum);
      logic [7:0]  cs;
      logic [31:0] w;
      cs = 8'd0;
      pulse_start();
      send_byte(len[7:0], gaps);
      send_byte(len[15:8], gaps);
      for (int i = 0; i < nwords; i++) begin
         w = words[i];
         sb.push_back({BASE + 32'(i), w});
         for (int k = 0; k < 4; k++) begin
            cs = cs ^ w[8*k +: 8];
            send_byte(w[8*k +: 8], gaps);
         end
      end
`ifdef IMEM_LOADER_CSUM_EN
      if (nwords > 0) send_byte(good_csum ? cs : ~cs, gaps);
`else
      if (good_csum) cs = 8'd0;
`endif
   endtask

   task automatic wait_end(input string name);
      int n;
      n = 0;
      while (!(done || error) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done/error within 40 cycles expected termination", name);
      end
   endtask

   initial begin
      int base_w;
      words = '{32'h00000713, 32'h00A00613};

      // Reset values
      @(negedge clk);
      #1;
      chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      chk("rst_wr_en",      {31'd0, imem_wr_en}, 32'd0);
      chk("rst_addr",       imem_addr, BASE);
      chk("rst_data",       imem_data, 32'd0);
      chk("rst_cpu_hold",   {31'd0, cpu_hold}, 32'd1);
      chk("rst_busy",       {31'd0, busy}, 32'd0);
      chk("rst_done",       {31'd0, done}, 32'd0);
      chk("rst_error",      {31'd0, error}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Case 1: two words back-to-back
      base_w = writes_seen;
      run_load(16'd2, 2, 1'b0, 1'b1);
      wait_end("c1");
      chk("c1_done",     {31'd0, done}, 32'd1);
      chk("c1_error",    {31'd0, error}, 32'd0);
      chk("c1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      chk("c1_busy",     {31'd0, busy}, 32'd0);
      chk("c1_ready",    {31'd0, byte_ready}, 32'd0);
      chk("c1_addr",     imem_addr, BASE + 32'd2);
      chk("c1_writes",   32'(writes_seen - base_w), 32'd2);
      chk("c1_sb_empty", 32'(sb.size()), 32'd0);

      // Case 2: zero length
      base_w = writes_seen;
      pulse_start();
      chk("c2_busy",     {31'd0, busy}, 32'd1);
      chk("c2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("c2_done_clr", {31'd0, done}, 32'd0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      wait_end("c2");
      chk("c2_done",   {31'd0, done}, 32'd1);
      chk("c2_error",  {31'd0, error}, 32'd0);
      chk("c2_writes", 32'(writes_seen - base_w), 32'd0);

      // Case 3: length 33 exceeds depth
      base_w = writes_seen;
      run_load(16'd33, 0, 1'b0, 1'b1);
      wait_end("c3");
      chk("c3_error",    {31'd0, error}, 32'd1);
      chk("c3_done",     {31'd0, done}, 32'd0);
      chk("c3_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("c3_ready",    {31'd0, byte_ready}, 32'd0);
      chk("c3_busy",     {31'd0, busy}, 32'd0);
      chk("c3_writes",   32'(writes_seen - base_w), 32'd0);

      // Case 4: case 1 with random valid gaps
      base_w = writes_seen;
      run_load(16'd2, 2, 1'b1, 1'b1);
      wait_end("c4");
      chk("c4_done",     {31'd0, done}, 32'd1);
      chk("c4_error",    {31'd0, error}, 32'd0);
      chk("c4_writes",   32'(writes_seen - base_w), 32'd2);
      chk("c4_sb_empty", 32'(sb.size()), 32'd0);

      // Case 5: reset after half of word 1
      base_w = writes_seen;
      pulse_start();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      sb.push_back({BASE, 32'h00000713});
      send_byte(8'h13, 1'b0);
      send_byte(8'h07, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h13, 1'b0);
      send_byte(8'h06, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("c5_ready",    {31'd0, byte_ready}, 32'd0);
      chk("c5_wr_en",    {31'd0, imem_wr_en}, 32'd0);
      chk("c5_addr",     imem_addr, BASE);
      chk("c5_data",     imem_data, 32'd0);
      chk("c5_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("c5_busy",     {31'd0, busy}, 32'd0);
      chk("c5_done",     {31'd0, done}, 32'd0);
      chk("c5_error",    {31'd0, error}, 32'd0);
      repeat (3) @(negedge clk);
      chk("c5_writes",   32'(writes_seen - base_w), 32'd1);
      chk("c5_sb_empty", 32'(sb.size()), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef IMEM_LOADER_CSUM_EN
      // Case 6: wrong checksum still writes the words, then errors
      base_w = writes_seen;
      run_load(16'd2, 2, 1'b0, 1'b0);
      wait_end("c6");
      chk("c6_error",    {31'd0, error}, 32'd1);
      chk("c6_done",     {31'd0, done}, 32'd0);
      chk("c6_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("c6_writes",   32'(writes_seen - base_w), 32'd2);
`endif

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
